// File: rtl/alu_issue_stage.sv
// Issue stage: decodes a SimpleRISC instruction into the one-hot ALU control word and the extended immediate, with operands latched alongside.
// Latency 1 cycle; a 2-entry skid (main + skid) keeps full throughput; in_ready is registered and drops while the skid is occupied.
// ISSUE_NOP_SQUASH_EN: when defined, instructions with an all-zero control word are accepted but never enqueued.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] aluSignals,
    output logic        isImmediate,
    output logic [31:0] immx,
    output logic [31:0] A_ALU,
    output logic [31:0] B_ALU
);

    typedef struct packed {
        logic [12:0] alu;
        logic        isimm;
        logic [31:0] immx;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    logic [4:0]  w_opc;
    logic [15:0] w_imm16;
    logic [12:0] w_alu;
    logic        w_isimm;
    logic [31:0] w_immx;
    entry_t      w_new;
    logic        w_acc;
    logic        w_enq;
    logic        w_unused_inst;

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_vld;
    logic   r_skid_vld;
    logic   r_in_ready;

    assign w_opc         = inst[31:27];
    assign w_imm16       = inst[15:0];
    assign w_unused_inst = ^inst[25:18];

    always_comb begin
        w_alu = '0;
        case (w_opc)
            5'b00000, 5'b01110, 5'b01111: w_alu[0]  = 1'b1;
            5'b00001:                     w_alu[1]  = 1'b1;
            5'b00101:                     w_alu[2]  = 1'b1;
            5'b00010:                     w_alu[3]  = 1'b1;
            5'b00011:                     w_alu[4]  = 1'b1;
            5'b00100:                     w_alu[5]  = 1'b1;
            5'b01010:                     w_alu[6]  = 1'b1;
            5'b01011:                     w_alu[7]  = 1'b1;
            5'b01100:                     w_alu[8]  = 1'b1;
            5'b00111:                     w_alu[9]  = 1'b1;
            5'b00110:                     w_alu[10] = 1'b1;
            5'b01000:                     w_alu[11] = 1'b1;
            5'b01001:                     w_alu[12] = 1'b1;
            default:                      w_alu     = '0;
        endcase
    end

    // ld/st always address with an immediate; non-ALU slots never claim one
    always_comb begin
        w_isimm = 1'b0;
        if (w_opc == 5'b01110 || w_opc == 5'b01111)
            w_isimm = 1'b1;
        else if (w_alu != '0)
            w_isimm = inst[26];
    end

    always_comb begin
        case (inst[17:16])
            2'b01:   w_immx = {16'h0000, w_imm16};
            2'b10:   w_immx = {w_imm16, 16'h0000};
            default: w_immx = {{16{w_imm16[15]}}, w_imm16};
        endcase
    end

    assign w_new = '{alu: w_alu, isimm: w_isimm, immx: w_immx, a: op1, b: op2};
    assign w_acc = in_valid && r_in_ready;

`ifdef ISSUE_NOP_SQUASH_EN
    assign w_enq = w_acc && (w_alu != '0);
`else
    assign w_enq = w_acc;
`endif

    // Main only advances when empty or consumed, so outputs hold under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (!r_main_vld || out_ready) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= w_enq;
                r_in_ready <= !w_enq;
                if (w_enq)
                    r_skid <= w_new;
            end else begin
                r_main_vld <= w_enq;
                r_in_ready <= 1'b1;
                if (w_enq)
                    r_main <= w_new;
            end
        end else if (w_enq) begin
            r_skid     <= w_new;
            r_skid_vld <= 1'b1;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= !r_skid_vld;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_vld;
    assign aluSignals  = r_main.alu;
    assign isImmediate = r_main.isimm;
    assign immx        = r_main.immx;
    assign A_ALU       = r_main.a;
    assign B_ALU       = r_main.b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: scoreboard of expected issue entries, compared when EX consumes.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid, isImmediate;
    logic [31:0] inst, op1, op2, immx, A_ALU, B_ALU;
    logic [12:0] aluSignals;

`ifdef ISSUE_NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready), .aluSignals(aluSignals),
        .isImmediate(isImmediate), .immx(immx), .A_ALU(A_ALU), .B_ALU(B_ALU)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] alu;
        logic        isimm;
        logic [31:0] immx;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   bit_of[32];
    logic rand_rdy_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic ibit,
                                       input logic [1:0] modf, input logic [15:0] imm);
        return {opc, ibit, 8'h00, modf, imm};
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   k;
        k       = bit_of[i[31:27]];
        e.alu   = (k >= 0) ? 13'(1 << k) : 13'h0;
        e.isimm = (i[31:27] == 5'd14 || i[31:27] == 5'd15) ? 1'b1 : ((e.alu != 0) && i[26]);
        if (i[17:16] == 2'b01)      e.immx = {16'h0, i[15:0]};
        else if (i[17:16] == 2'b10) e.immx = {i[15:0], 16'h0};
        else                        e.immx = 32'(signed'(i[15:0]));
        e.a = a;
        e.b = b;
        return e;
    endfunction

    // Scoreboard: every consumed entry must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_issue", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_alu", 32'(aluSignals), 32'(e.alu));
                check("sb_isimm", 32'(isImmediate), 32'(e.isimm));
                check("sb_immx", immx, e.immx);
                check("sb_A", A_ALU, e.a);
                check("sb_B", B_ALU, e.b);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy_en) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int   t;
        exp_t e;
        inst = i; op1 = a; op2 = b; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        e = model(i, a, b);
        if (!(SQUASH && e.alu == 0)) sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 32; k++) bit_of[k] = -1;
        bit_of[0] = 0;  bit_of[14] = 0; bit_of[15] = 0;
        bit_of[1] = 1;  bit_of[5] = 2;  bit_of[2] = 3;  bit_of[3] = 4;  bit_of[4] = 5;
        bit_of[10] = 6; bit_of[11] = 7; bit_of[12] = 8; bit_of[7] = 9;  bit_of[6] = 10;
        bit_of[8] = 11; bit_of[9] = 12;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu", 32'(aluSignals), 32'd0);
        check("rst_immx", immx, 32'd0);
        check("rst_A", A_ALU, 32'd0);
        reset = 1'b0;

        // add with sign-extended 0xFFFF, one-cycle latency
        out_ready = 1'b1;
        push(mk(5'b00000, 1'b1, 2'b00, 16'hFFFF), 32'd5, 32'd7);
        check("add_vld", 32'(out_valid), 32'd1);
        check("add_alu", 32'(aluSignals), 32'h0001);
        check("add_isimm", 32'(isImmediate), 32'd1);
        check("add_immx", immx, 32'hFFFF_FFFF);
        check("add_A", A_ALU, 32'd5);
        @(posedge clk); #1;
        check("bubble_vld", 32'(out_valid), 32'd0);
        check("hold_immx", immx, 32'hFFFF_FFFF);

        push(mk(5'b01001, 1'b1, 2'b10, 16'h1234), 32'd1, 32'd2);
        check("mov_alu", 32'(aluSignals), 32'h1000);
        check("mov_hi_immx", immx, 32'h1234_0000);
        push(mk(5'b01001, 1'b1, 2'b01, 16'h8000), 32'd1, 32'd2);
        check("mov_zx_immx", immx, 32'h0000_8000);
        push(mk(5'b01110, 1'b0, 2'b00, 16'h0010), 32'd3, 32'd4);
        check("ld_isimm", 32'(isImmediate), 32'd1);
        check("ld_alu", 32'(aluSignals), 32'h0001);

        // back-to-back throughput
        c0 = cyc;
        for (int k = 0; k < 4; k++) push(mk(5'(k + 1), 1'b0, 2'b00, 16'(k)), 32'(k), 32'(k * 3));
        check("throughput_cycles", 32'(cyc - c0), 32'd4);
        drain("drain_tput");

        // back-pressure: sub, mul fill main+skid, or waits
        out_ready = 1'b0;
        push(mk(5'b00001, 1'b0, 2'b00, 16'h0), 32'd10, 32'd11);
        push(mk(5'b00010, 1'b0, 2'b00, 16'h0), 32'd12, 32'd13);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        inst = mk(5'b00111, 1'b1, 2'b01, 16'h00FF); op1 = 32'd14; op2 = 32'd15; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_alu", 32'(aluSignals), 32'h0002);
        check("bp_hold_A", A_ALU, 32'd10);
        check("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        push(mk(5'b00111, 1'b1, 2'b01, 16'h00FF), 32'd14, 32'd15);
        drain("drain_bp");

        // flush with skid full and an offered instruction
        out_ready = 1'b0;
        push(mk(5'b00001, 1'b0, 2'b00, 16'h0), 32'd20, 32'd21);
        push(mk(5'b00010, 1'b0, 2'b00, 16'h0), 32'd22, 32'd23);
        inst = mk(5'b00110, 1'b0, 2'b00, 16'h0); in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("flush_vld", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        // flush also discards an entry accepted in the same cycle
        push(mk(5'b00001, 1'b0, 2'b00, 16'h0), 32'd30, 32'd31);
        inst = mk(5'b00110, 1'b0, 2'b00, 16'h0); in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("flush_no_issue", 32'(out_valid), 32'd0);

        // nop then cmp
        push(mk(5'b01101, 1'b1, 2'b00, 16'h0), 32'd40, 32'd41);
        if (SQUASH) check("nop_squashed", 32'(out_valid), 32'd0);
        else        check("nop_issued", 32'(out_valid), 32'd1);
        check("nop_isimm", 32'(isImmediate & out_valid), 32'd0);
        push(mk(5'b00101, 1'b0, 2'b00, 16'h0), 32'd42, 32'd43);
        check("cmp_alu", 32'(aluSignals), 32'h0004);
        push(mk(5'b11000, 1'b1, 2'b00, 16'h0), 32'd44, 32'd45);
        drain("drain_nop");

        // random traffic under random back-pressure
        rand_rdy_en = 1'b1;
        for (int k = 0; k < 24; k++)
            push({5'($urandom_range(0, 31)), 27'($urandom)}, $urandom, $urandom);
        rand_rdy_en = 1'b0;
        @(posedge clk); #2;
        drain("drain_rand");

        // async reset with main and skid both full
        out_ready = 1'b0;
        push(mk(5'b00001, 1'b1, 2'b10, 16'hABCD), 32'd50, 32'd51);
        push(mk(5'b00010, 1'b1, 2'b00, 16'h8001), 32'd52, 32'd53);
        check("pre_rst_vld", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        sb.delete();
        check("arst_vld", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_alu", 32'(aluSignals), 32'd0);
        check("arst_isimm", 32'(isImmediate), 32'd0);
        check("arst_immx", immx, 32'd0);
        check("arst_A", A_ALU, 32'd0);
        check("arst_B", B_ALU, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("post_rst_vld", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
